ps2_scancode_decoder: RTL

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_scancode_decoder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: folds E0/F0 prefixes into key events,
// tracks shift/caps-lock modifiers, held key, press count and ASCII mapping.
module ps2_scancode_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_code,
  output logic       out_valid,
  output logic       out_make,
  output logic       out_ext,
  output logic [7:0] out_code,
  output logic [7:0] out_ascii,
  output logic       held,
  output logic [7:0] press_count,
  output logic       shift_state,
  output logic       caps_lock
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_e;

  state_e     state_q;
  logic       out_valid_q;
  logic       out_make_q;
  logic       out_ext_q;
  logic [7:0] out_code_q;
  logic [7:0] out_ascii_q;
  logic       held_q;
  logic [7:0] press_count_q;
  logic       lshift_q;
  logic       rshift_q;
  logic       caps_q;
  logic       caps_held_q;
  logic [8:0] last_key_q;

  logic       is_e0;
  logic       is_f0;
  logic       is_noise;
  logic       cur_ext;
  logic       cur_brk;
  logic [8:0] cur_key;
  logic       mod_lshift;
  logic       mod_rshift;
  logic       mod_caps;
  logic [7:0] ascii_d;

  // Letter map: returns lowercase ASCII, or 0 when the code is not a letter.
  function automatic logic [7:0] letter_of(input logic [7:0] code);
    logic [7:0] r;
    case (code)
      8'h1C: r = 8'h61;  8'h32: r = 8'h62;  8'h21: r = 8'h63;  8'h23: r = 8'h64;
      8'h24: r = 8'h65;  8'h2B: r = 8'h66;  8'h34: r = 8'h67;  8'h33: r = 8'h68;
      8'h43: r = 8'h69;  8'h3B: r = 8'h6A;  8'h42: r = 8'h6B;  8'h4B: r = 8'h6C;
      8'h3A: r = 8'h6D;  8'h31: r = 8'h6E;  8'h44: r = 8'h6F;  8'h4D: r = 8'h70;
      8'h15: r = 8'h71;  8'h2D: r = 8'h72;  8'h1B: r = 8'h73;  8'h2C: r = 8'h74;
      8'h3C: r = 8'h75;  8'h2A: r = 8'h76;  8'h1D: r = 8'h77;  8'h22: r = 8'h78;
      8'h35: r = 8'h79;  8'h1A: r = 8'h7A;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Digit row and whitespace keys; shift selects the symbol row.
  function automatic logic [7:0] other_of(input logic [7:0] code, input logic shift);
    logic [7:0] r;
    case (code)
      8'h45: r = shift ? 8'h29 : 8'h30;
      8'h16: r = shift ? 8'h21 : 8'h31;
      8'h1E: r = shift ? 8'h40 : 8'h32;
      8'h26: r = shift ? 8'h23 : 8'h33;
      8'h25: r = shift ? 8'h24 : 8'h34;
      8'h2E: r = shift ? 8'h25 : 8'h35;
      8'h36: r = shift ? 8'h5E : 8'h36;
      8'h3D: r = shift ? 8'h26 : 8'h37;
      8'h3E: r = shift ? 8'h2A : 8'h38;
      8'h46: r = shift ? 8'h28 : 8'h39;
      8'h29: r = 8'h20;
      8'h5A: r = 8'h0D;
      8'h66: r = 8'h08;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Decode the incoming byte against the current prefix state.
  always_comb begin
    is_e0      = (in_code == 8'hE0);
    is_f0      = (in_code == 8'hF0);
    is_noise   = (state_q == S_IDLE) &&
                 ((in_code == 8'hAA) || (in_code == 8'hFA) || (in_code == 8'hEE) ||
                  (in_code == 8'hFE) || (in_code == 8'h00) || (in_code == 8'hFF));
    cur_ext    = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    cur_brk    = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    cur_key    = {cur_ext, in_code};
    mod_lshift = !cur_ext && (in_code == 8'h12);
    mod_rshift = !cur_ext && (in_code == 8'h59);
    mod_caps   = !cur_ext && (in_code == 8'h58);
    ascii_d    = '0;
    if (!cur_ext) begin
      if (letter_of(in_code) != 8'h00) begin
        // Uppercase letters sit 0x20 below lowercase.
        ascii_d = ((lshift_q | rshift_q) ^ caps_q) ? (letter_of(in_code) - 8'h20)
                                                   : letter_of(in_code);
      end else begin
        ascii_d = other_of(in_code, lshift_q | rshift_q);
      end
    end
  end

  // Prefix FSM, event registers and key-tracking state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      out_make_q    <= 1'b0;
      out_ext_q     <= 1'b0;
      out_code_q    <= '0;
      out_ascii_q   <= '0;
      held_q        <= 1'b0;
      press_count_q <= '0;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      caps_q        <= 1'b0;
      caps_held_q   <= 1'b0;
      last_key_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (in_valid) begin
        if (is_e0) begin
          state_q <= S_EXT;
        end else if (is_f0) begin
          state_q <= cur_ext ? S_EXT_BRK : S_BRK;
        end else if (!is_noise) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b1;
          out_make_q  <= !cur_brk;
          out_ext_q   <= cur_ext;
          out_code_q  <= in_code;
          out_ascii_q <= ascii_d;
          if (mod_lshift) begin
            lshift_q <= !cur_brk;
          end else if (mod_rshift) begin
            rshift_q <= !cur_brk;
          end else if (mod_caps) begin
            // caps_held_q marks the key as down so typematic repeats do not re-toggle.
            if (cur_brk) begin
              caps_held_q <= 1'b0;
            end else if (!caps_held_q) begin
              caps_held_q <= 1'b1;
              caps_q      <= ~caps_q;
            end
          end else if (!cur_brk) begin
            if (!(held_q && (last_key_q == cur_key))) begin
              last_key_q    <= cur_key;
              held_q        <= 1'b1;
              press_count_q <= press_count_q + 8'd1;
            end
          end else if (last_key_q == cur_key) begin
            held_q <= 1'b0;
          end
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_make    = out_make_q;
  assign out_ext     = out_ext_q;
  assign out_code    = out_code_q;
  assign out_ascii   = out_ascii_q;
  assign held        = held_q;
  assign press_count = press_count_q;
  assign shift_state = lshift_q | rshift_q;
  assign caps_lock   = caps_q;

endmodule
